// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions for the pipelined core.
// Holds the opcode constants, the instruction-format enum and the packed
// decode-result struct. The struct's register fields are always the raw
// 5-bit instruction-field width. Each consumer truncates them to its own
// register-address width.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_used;
    logic       rs2_used;
    logic       reg_write;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/reg_field_decode.sv
// Purely combinational register-field decoder, shared with the forwarding unit.
// Ports:
//   instr - 32-bit instruction word
//   dec   - decoded rs1/rs2/rd, their use flags, reg_write and illegal
// Fields that the format does not use read as 0. reg_write is never set for
// x0. Unknown opcodes, and any used field that is outside the register file
// (RV32E), raise illegal. An illegal result also drops reg_write.
module reg_field_decode
  import rv_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  fmt_e       fmt_s;
  logic       rd_used_s;
  logic       range_bad_s;
  logic [4:0] f_rs1_s;
  logic [4:0] f_rs2_s;
  logic [4:0] f_rd_s;
  logic       unused_funct_s;

  assign f_rd_s  = instr[11:7];
  assign f_rs1_s = instr[19:15];
  assign f_rs2_s = instr[24:20];
  // funct3/funct7 select the operation, not registers, so they are not decoded here
  assign unused_funct_s = ^{instr[31:25], instr[14:12]};

  // Opcode to instruction format
  always_comb begin
    fmt_s = FMT_BAD;
    case (instr[6:0])
      OP_R:                      fmt_s = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:  fmt_s = FMT_I;
      OP_STORE:                  fmt_s = FMT_S;
      OP_BRANCH:                 fmt_s = FMT_B;
      OP_LUI, OP_AUIPC:          fmt_s = FMT_U;
      OP_JAL:                    fmt_s = FMT_J;
      default:                   fmt_s = FMT_BAD;
    endcase
  end

  // Format to field usage, range check and final decode result
  always_comb begin
    dec         = '0;
    rd_used_s   = 1'b0;
    range_bad_s = 1'b0;
    case (fmt_s)
      FMT_R: begin
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
        rd_used_s    = 1'b1;
      end
      FMT_I: begin
        dec.rs1_used = 1'b1;
        rd_used_s    = 1'b1;
      end
      FMT_S, FMT_B: begin
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      FMT_U, FMT_J: begin
        rd_used_s = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase

    dec.rs1 = dec.rs1_used ? f_rs1_s : 5'd0;
    dec.rs2 = dec.rs2_used ? f_rs2_s : 5'd0;
    dec.rd  = rd_used_s    ? f_rd_s  : 5'd0;

    range_bad_s = (dec.rs1_used && ({27'd0, f_rs1_s} >= NREG)) ||
                  (dec.rs2_used && ({27'd0, f_rs2_s} >= NREG)) ||
                  (rd_used_s    && ({27'd0, f_rd_s}  >= NREG));

    if (range_bad_s) begin
      dec.illegal = 1'b1;
    end else begin
      dec.illegal = dec.illegal;
    end

    dec.reg_write = rd_used_s && (f_rd_s != 5'd0) && !dec.illegal;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Busy-bit register scoreboard and issue-stall logic for the pipelined core.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   instr, instr_valid    - instruction offered for issue this cycle
//   flush                 - kills every pending write
//   wb_valid, wb_rd       - writeback completing this cycle
//   rs1, rs2, rd          - decoded fields (0 when unused)
//   reg_write, illegal    - decode flags
//   issue, stall          - instruction accepted / held this cycle
//   busy_vec, inflight    - scoreboard state and outstanding-write count
//   stall_cnt             - saturating count of hazard stall cycles
//   wb_err                - sticky: a writeback hit a non-busy register
module reg_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG         = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int BYPASS_WB    = 1,
  parameter int STALL_W      = 16,
  localparam int AW = $clog2(NREG),
  localparam int IW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic [AW-1:0]      wb_rd,
  output logic [AW-1:0]      rs1,
  output logic [AW-1:0]      rs2,
  output logic [AW-1:0]      rd,
  output logic               reg_write,
  output logic               illegal,
  output logic               issue,
  output logic               stall,
  output logic [NREG-1:0]    busy_vec,
  output logic [IW-1:0]      inflight,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               wb_err
);

  dec_t            dec_s;
  logic [NREG-1:0] eb_s;
  logic            full_s;
  logic            hazard_s;
  logic            clr_s;
  logic            set_s;
  logic [NREG-1:0] busy_nxt_s;
  logic [IW-1:0]   inflight_nxt_s;

  reg_field_decode #(.NREG(NREG)) u_dec (
    .instr (instr),
    .dec   (dec_s)
  );

  assign rs1       = dec_s.rs1[AW-1:0];
  assign rs2       = dec_s.rs2[AW-1:0];
  assign rd        = dec_s.rd[AW-1:0];
  assign reg_write = dec_s.reg_write;
  assign illegal   = dec_s.illegal;

  assign full_s = (inflight == IW'(MAX_INFLIGHT));
  assign clr_s  = wb_valid && busy_vec[wb_rd];
  assign set_s  = issue && reg_write;

  // Effective busy bits and hazard detection; a same-cycle writeback can release a hazard
  always_comb begin
    eb_s = busy_vec;
    if ((BYPASS_WB != 0) && wb_valid) begin
      eb_s[wb_rd] = 1'b0;
    end else begin
      eb_s = busy_vec;
    end
    // x0 is never busy, so an unused field (forced to 0) cannot raise a hazard
    hazard_s = (dec_s.rs1_used && eb_s[rs1]) ||
               (dec_s.rs2_used && eb_s[rs2]) ||
               (reg_write && eb_s[rd]) ||
               (reg_write && full_s && !clr_s);
  end

  assign issue = rst_n && instr_valid && !illegal && !hazard_s && !flush;
  assign stall = instr_valid && !issue;

  // Next scoreboard contents and in-flight count; a set overrides a clear of the same register
  always_comb begin
    busy_nxt_s     = busy_vec;
    inflight_nxt_s = inflight;
    if (clr_s) begin
      busy_nxt_s[wb_rd] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (set_s) begin
      busy_nxt_s[rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
    case ({set_s, clr_s})
      2'b10:   inflight_nxt_s = full_s ? inflight : inflight + IW'(1);
      2'b01:   inflight_nxt_s = (inflight == '0) ? inflight : inflight - IW'(1);
      default: inflight_nxt_s = inflight;
    endcase
  end

  // Scoreboard, counters and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec  <= '0;
      inflight  <= '0;
      stall_cnt <= '0;
      wb_err    <= 1'b0;
    end else begin
      if (flush) begin
        busy_vec <= '0;
        inflight <= '0;
      end else begin
        busy_vec <= busy_nxt_s;
        inflight <= inflight_nxt_s;
        if (wb_valid && !busy_vec[wb_rd]) begin
          wb_err <= 1'b1;
        end
      end
      if (stall && !illegal && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (default parameters).
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;
  logic        issue;
  logic        stall;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;
  logic [15:0] stall_cnt;
  logic        wb_err;

  int checks;
  int errors;

  reg_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .issue       (issue),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .inflight    (inflight),
    .stall_cnt   (stall_cnt),
    .wb_err      (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input int r);
    addi = 32'h0010_0013 | (32'(r) << 7);
  endfunction

  task automatic drive(input logic [31:0] i, input logic v, input logic f,
                       input logic wv, input logic [4:0] wr);
    instr = i; instr_valid = v; flush = f; wb_valid = wv; wb_rd = wr;
    #1;
  endtask

  task automatic chk_state(input string name, input logic [31:0] b, input logic [2:0] n);
    chk({name, " busy_vec"}, busy_vec, b);
    chk({name, " inflight"}, {29'd0, inflight}, {29'd0, n});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // opcode-per-format decode table: instr, rs1, rs2, rd, reg_write, illegal
    vecs[0]  = '{32'h0020_81B3, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0}; // add x3,x1,x2
    vecs[1]  = '{32'h0053_2023, 5'd6,  5'd5,  5'd0,  1'b0, 1'b0}; // sw x5,0(x6)
    vecs[2]  = '{32'h0010_0293, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0}; // addi x5,x0,1
    vecs[3]  = '{32'h0044_2383, 5'd8,  5'd0,  5'd7,  1'b1, 1'b0}; // lw x7,4(x8)
    vecs[4]  = '{32'h0005_00E7, 5'd10, 5'd0,  5'd1,  1'b1, 1'b0}; // jalr x1,0(x10)
    vecs[5]  = '{32'h00C5_8F63, 5'd11, 5'd12, 5'd0,  1'b0, 1'b0}; // beq, imm bits in rd slot
    vecs[6]  = '{32'h1234_5A37, 5'd0,  5'd0,  5'd20, 1'b1, 1'b0}; // lui x20
    vecs[7]  = '{32'h0000_0017, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0}; // auipc x0
    vecs[8]  = '{32'h0000_0FEF, 5'd0,  5'd0,  5'd31, 1'b1, 1'b0}; // jal x31
    vecs[9]  = '{32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1}; // opcode 0x7F
    vecs[10] = '{32'h0000_0033, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0}; // add x0,x0,x0

    rst_n = 1'b1;
    drive(32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0);
    rst_n = 1'b0;
    #1;
    chk_state("reset", 32'h0, 3'd0);
    chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset wb_err", {31'd0, wb_err}, 32'd0);
    chk("reset issue", {31'd0, issue}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // decode sweep with instr_valid low so the scoreboard stays idle
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].instr, 1'b0, 1'b0, 1'b0, 5'd0);
      chk($sformatf("dec%0d rs1", i), {27'd0, rs1}, {27'd0, vecs[i].rs1});
      chk($sformatf("dec%0d rs2", i), {27'd0, rs2}, {27'd0, vecs[i].rs2});
      chk($sformatf("dec%0d rd", i), {27'd0, rd}, {27'd0, vecs[i].rd});
      chk($sformatf("dec%0d reg_write", i), {31'd0, reg_write}, {31'd0, vecs[i].rw});
      chk($sformatf("dec%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
    end

    // RAW stall resolved by a same-cycle writeback
    drive(addi(5), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("raw first issue", {31'd0, issue}, 32'd1);
    tick();
    chk_state("raw after addi", 32'h0000_0020, 3'd1);
    drive(32'h0052_8333, 1'b1, 1'b0, 1'b0, 5'd0); // add x6,x5,x5
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("raw stall c%0d", c), {31'd0, stall}, 32'd1);
      tick();
    end
    chk("raw stall_cnt", {16'd0, stall_cnt}, 32'd2);
    drive(32'h0052_8333, 1'b1, 1'b0, 1'b1, 5'd5);
    chk("raw bypass issue", {31'd0, issue}, 32'd1);
    chk("raw bypass stall", {31'd0, stall}, 32'd0);
    tick();
    chk_state("raw after add", 32'h0000_0040, 3'd1);
    chk("raw stall_cnt kept", {16'd0, stall_cnt}, 32'd2);
    drive(32'h0, 1'b0, 1'b0, 1'b1, 5'd6);
    tick();
    chk_state("raw drained", 32'h0, 3'd0);

    // capacity limit of four outstanding writes
    for (int r = 1; r <= 4; r++) begin
      drive(addi(r), 1'b1, 1'b0, 1'b0, 5'd0);
      tick();
    end
    chk_state("cap full", 32'h0000_001E, 3'd4);
    drive(addi(7), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("cap stall", {31'd0, stall}, 32'd1);
    tick();
    chk("cap stall_cnt", {16'd0, stall_cnt}, 32'd3);
    drive(addi(7), 1'b1, 1'b0, 1'b1, 5'd1);
    chk("cap wb issue", {31'd0, issue}, 32'd1);
    tick();
    chk_state("cap swap", 32'h0000_009C, 3'd4);
    for (int k = 0; k < 4; k++) begin
      drive(32'h0, 1'b0, 1'b0, 1'b1, (k == 3) ? 5'd7 : 5'(k + 2));
      tick();
    end
    chk_state("cap drained", 32'h0, 3'd0);

    // WAW and set/clear collision on x8
    drive(addi(8), 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    drive(addi(8), 1'b1, 1'b0, 1'b0, 5'd0);
    chk("waw stall", {31'd0, stall}, 32'd1);
    tick();
    drive(addi(8), 1'b1, 1'b0, 1'b1, 5'd8);
    chk("collide issue", {31'd0, issue}, 32'd1);
    tick();
    chk_state("collide", 32'h0000_0100, 3'd1);
    chk("collide stall_cnt", {16'd0, stall_cnt}, 32'd4);

    // flush with three pending, plus a writeback that flush must suppress
    drive(addi(10), 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    drive(addi(11), 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    chk_state("pre flush", 32'h0000_0D00, 3'd3);
    drive(addi(12), 1'b1, 1'b1, 1'b1, 5'd9);
    chk("flush issue", {31'd0, issue}, 32'd0);
    tick();
    chk_state("post flush", 32'h0, 3'd0);
    chk("flush wb_err", {31'd0, wb_err}, 32'd0);
    chk("flush stall_cnt", {16'd0, stall_cnt}, 32'd4);
    drive(32'h0, 1'b0, 1'b0, 1'b1, 5'd9);
    tick();
    chk("wb_err set", {31'd0, wb_err}, 32'd1);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    chk("wb_err sticky", {31'd0, wb_err}, 32'd1);

    // illegal instruction: no issue, no stall count
    drive(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("illegal issue", {31'd0, issue}, 32'd0);
    chk("illegal stall", {31'd0, stall}, 32'd1);
    tick();
    chk("illegal stall_cnt", {16'd0, stall_cnt}, 32'd4);

    // asynchronous reset in the middle of a cycle
    drive(addi(4), 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    drive(addi(5), 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    chk_state("pre reset", 32'h0000_0030, 3'd2);
    drive(addi(6), 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_state("async reset", 32'h0, 3'd0);
    chk("async reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("async reset wb_err", {31'd0, wb_err}, 32'd0);
    chk("async reset issue", {31'd0, issue}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Parametrised successor to the single-cycle register-field decoder, for the pipelined core.
- Decodes register usage for every RV32I format.
- Tracks registers with pending writebacks in a busy-bit scoreboard.
- Stalls issue on RAW/WAW hazards or when in-flight capacity is exhausted.
- Sits between fetch/decode and the register file/execute stages; the writeback stage clears busy bits.

Parameters:
NREG, 32, architectural register count; 32 (RV32I) or 16 (RV32E); derived AW = $clog2(NREG)
MAX_INFLIGHT, 4, maximum outstanding register writes (1..NREG-1)
BYPASS_WB, 1, if 1 a same-cycle writeback to a source/dest register resolves its hazard
STALL_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction word
instr_valid  in  1  instr holds a valid instruction this cycle
flush  in  1  pipeline flush; kills all pending writes
wb_valid  in  1  writeback completing this cycle
wb_rd  in  AW  writeback destination
rs1  out  AW  decoded source 1 (0 when unused)
rs2  out  AW  decoded source 2 (0 when unused)
rd  out  AW  decoded destination (0 when unused)
reg_write  out  1  instruction writes rd (never for rd==0)
illegal  out  1  unknown opcode, or field >= NREG
issue  out  1  instruction accepted this cycle
stall  out  1  instr_valid && !issue
busy_vec  out  NREG  scoreboard state
inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding write count
stall_cnt  out  STALL_W  saturating count of stall cycles
wb_err  out  1  sticky: writeback to a non-busy register

Behaviour:
- Reset (async, rst_n=0): busy_vec=0, inflight=0, stall_cnt=0, wb_err=0. Combinational outputs follow inputs; issue=0 while in reset.
- Decode (combinational, fully assigned, no latches; unused fields drive 0):
  - R 0110011: rd, rs1, rs2
  - I-ALU 0010011, LOAD 0000011, JALR 1100111: rd, rs1
  - STORE 0100011, BRANCH 1100011: rs1, rs2
  - LUI 0110111, AUIPC 0010111, JAL 1101111: rd only
  - Any other opcode: illegal=1, all fields 0, reg_write=0.
  - Any used field with value >= NREG: illegal=1.
- rs1_used / rs2_used are internal flags set per format. x0 is never a hazard source.
- Effective busy: eb[r] = busy_vec[r] && !(BYPASS_WB && wb_valid && wb_rd==r).
- Hazard when any of:
  - rs1_used && eb[rs1]
  - rs2_used && eb[rs2]
  - reg_write && eb[rd] (WAW)
  - reg_write && inflight==MAX_INFLIGHT && !(wb_valid && busy_vec[wb_rd])
- issue = instr_valid && !illegal && !hazard && !flush. Illegal instructions are neither issued nor counted as stalls.
- Next state (single always_ff):
  - Clear: wb_valid && busy_vec[wb_rd] clears busy[wb_rd].
  - Set: issue && reg_write sets busy[rd].
  - Same register set and cleared in one cycle: the set wins.
  - inflight += (issue&&reg_write) - (wb_valid&&busy_vec[wb_rd]); it never exceeds MAX_INFLIGHT and never underflows.
  - wb_valid to a non-busy register, or to wb_rd=0: no state change, wb_err<=1 (sticky until reset).
  - flush: busy_vec<=0, inflight<=0 next edge; it overrides same-cycle sets and clears, and wb_err is not raised that cycle.
  - busy_vec[0] is hardwired 0.
- stall_cnt increments when stall && !illegal && !flush, and saturates at all-ones.
- Latency: the scoreboard update is visible the cycle after issue. Back-to-back dependent instructions stall until the writeback cycle (BYPASS_WB=1) or the cycle after (BYPASS_WB=0).

Decomposition:
- Shared package rv_pkg: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), instruction-format enum, and a decode-result struct {rs1, rs2, rd, rs1_used, rs2_used, reg_write, illegal}.
- One sub-module, reg_field_decode: purely combinational instr -> struct. It is reused by the forwarding unit.
- Scoreboard, counters and hazard logic stay in reg_scoreboard.

Test Plan:
- Reset mid-operation: busy_vec=0x0000_0030, rst_n pulsed low asynchronously -> busy_vec=0, inflight=0, stall_cnt=0 immediately.
- Decode sweep: issue one of each format, e.g. add x3,x1,x2 (0x002081B3) -> rd=3, rs1=1, rs2=2, reg_write=1. sw x5,0(x6) -> rd=0, reg_write=0. Opcode 0x7F -> illegal=1, issue=0.
- RAW stall: issue addi x5,x0,1, then add x6,x5,x5 -> stall=1 until wb_valid, wb_rd=5. With BYPASS_WB=1, issue in that same cycle, stall_cnt = stalled cycles.
- Capacity: MAX_INFLIGHT=4, issue writes to x1..x4, then a write to x7 -> stall. A same-cycle wb to x1 -> issue=1, inflight stays 4.
- Set/clear collision and WAW: busy[8]=1, wb_rd=8 while issuing a write to x8 (BYPASS_WB=1) -> busy[8] stays 1, inflight unchanged.
- Flush and error: flush with 3 pending -> busy_vec=0, inflight=0 next cycle. A later wb to x9 (not busy) -> wb_err=1 and stays set.
